// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter sequencing with jump, call/return and a
// bounded LIFO return-address stack that raises sticky overflow/underflow flags.
module fetch_stage #(
    parameter int PC_W  = 10,
    parameter int STK_D = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_inc,
    input  logic [PC_W-1:0]          dir,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     stall,
    output logic [PC_W-1:0]          pc,
    output logic [$clog2(STK_D):0]   depth,
    output logic                     stk_ovf,
    output logic                     stk_unf
);

    localparam int AW = $clog2(STK_D);
    localparam int DW = AW + 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [PC_W-1:0] stk_q [STK_D];
    logic [PC_W-1:0] stk_d [STK_D];

    logic [PC_W-1:0] pc_inc;
    logic [DW-1:0]   depth_dec;
    logic [AW-1:0]   top_idx;
    logic [AW-1:0]   push_idx;

    assign pc_inc    = pc_q + PC_W'(1);
    assign depth_dec = depth_q - DW'(1);
    assign top_idx   = depth_dec[AW-1:0];
    assign push_idx  = depth_q[AW-1:0];

    // Priority: stall > ret > call > jump > increment.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stk_d   = stk_q;
        if (!stall) begin
            if (ret) begin
                if (depth_q != '0) begin
                    pc_d    = stk_q[top_idx];
                    depth_d = depth_dec;
                end else begin
                    unf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (call) begin
                if (depth_q < DW'(STK_D)) begin
                    stk_d[push_idx] = pc_inc;
                    depth_d         = depth_q + DW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
                pc_d = dir;
            end else if (!s_inc) begin
                pc_d = dir;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < STK_D; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            stk_q   <= stk_d;
        end
    end

    assign pc      = pc_q;
    assign depth   = depth_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule
